// File: rtl/axi_slave_mem_responder_if.sv
// AXI4 bundle between a master and the memory responder.
// Clock and reset are kept as plain ports on the modules that use this interface.
interface axi_slave_mem_responder_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  localparam int STRB_W = DATA_W / 8;

  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;

  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_slave_mem_responder.sv
// AXI4 slave backed by a word-addressed memory; independent write and read FSMs,
// one outstanding transaction per channel.
//
// state  | meaning
// W_IDLE | awready high, waiting for an AW handshake
// W_DATA | wready high, absorbing write beats
// W_RESP | bvalid high, holding the response until bready
// R_IDLE | arready high, waiting for an AR handshake
// R_DATA | rvalid high, presenting read beats back-to-back
module axi_slave_mem_responder #(
  parameter int                ID_W      = 4,
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 64,
  parameter int                MEM_DEPTH = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input logic                        aclk,
  input logic                        aresetn,
  axi_slave_mem_responder_if.slave   axi
);
  localparam int STRB_W  = DATA_W / 8;
  localparam int LG_STRB = $clog2(STRB_W);
  localparam int IDX_W   = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  function automatic logic [ADDR_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return (a - BASE_ADDR) >> LG_STRB;
  endfunction

  function automatic logic in_range(input logic [ADDR_W-1:0] idx);
    return idx < ADDR_W'(MEM_DEPTH);
  endfunction

  // WRAP and the reserved encoding are rejected along with oversized beats
  function automatic logic bad_xfer(input logic [2:0] size, input logic [1:0] burst);
    return burst[1] || (size > 3'(LG_STRB));
  endfunction

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [2:0] size,
                                                  input logic [1:0] burst);
    return (burst == 2'b01) ? a + (ADDR_W'(1) << size) : a;
  endfunction

  // ---------------- write channel ----------------
  w_state_t          w_state;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_len;
  logic [7:0]        w_cnt;
  logic [2:0]        w_size;
  logic [1:0]        w_burst;
  logic              w_slverr;
  logic              w_decerr;
  logic              awready_q;
  logic              wready_q;
  logic              bvalid_q;
  logic [1:0]        bresp_q;
  logic [ID_W-1:0]   bid_q;

  logic [ADDR_W-1:0] w_idx;
  logic              w_beat;
  logic              w_bad;
  logic              w_oob;
  logic              w_we;
  logic              w_cnt_last;
  logic              w_end;
  logic              w_slv_acc;
  logic              w_dec_acc;

  always_comb begin
    w_idx      = word_idx(w_addr);
    w_beat     = (w_state == W_DATA) && axi.wvalid && wready_q;
    w_bad      = bad_xfer(w_size, w_burst);
    w_oob      = !in_range(w_idx);
    w_we       = w_beat && !w_bad && !w_oob;
    w_cnt_last = (w_cnt == w_len);
    w_end      = axi.wlast || w_cnt_last;
    w_dec_acc  = w_decerr || (w_oob && !w_bad);
    w_slv_acc  = w_slverr || w_bad || (axi.wlast != w_cnt_last);
  end

  always_ff @(posedge aclk) begin
    if (w_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (axi.wstrb[b]) mem[w_idx[IDX_W-1:0]][b*8 +: 8] <= axi.wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state   <= W_IDLE;
      w_addr    <= '0;
      w_len     <= '0;
      w_cnt     <= '0;
      w_size    <= '0;
      w_burst   <= '0;
      w_slverr  <= 1'b0;
      w_decerr  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      bid_q     <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (axi.awvalid && awready_q) begin
            w_addr    <= axi.awaddr;
            w_len     <= axi.awlen;
            w_size    <= axi.awsize;
            w_burst   <= axi.awburst;
            bid_q     <= axi.awid;
            w_cnt     <= '0;
            w_slverr  <= 1'b0;
            w_decerr  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            w_state   <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_beat) begin
            w_addr   <= next_addr(w_addr, w_size, w_burst);
            w_cnt    <= w_cnt + 8'd1;
            w_slverr <= w_slv_acc;
            w_decerr <= w_dec_acc;
            if (w_end) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= w_dec_acc ? 2'b11 : (w_slv_acc ? 2'b10 : 2'b00);
              w_state  <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (axi.bready) begin
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            awready_q <= 1'b1;
            w_state   <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // ---------------- read channel ----------------
  r_state_t          r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_len;
  logic [7:0]        r_cnt;
  logic [2:0]        r_size;
  logic [1:0]        r_burst;
  logic              arready_q;
  logic              rvalid_q;
  logic              rlast_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;
  logic [ID_W-1:0]   rid_q;

  logic [ADDR_W-1:0] rf_addr;
  logic [2:0]        rf_size;
  logic [1:0]        rf_burst;
  logic [ADDR_W-1:0] rf_idx;
  logic              rf_bad;
  logic              rf_oob;
  logic [DATA_W-1:0] rf_data;
  logic [1:0]        rf_resp;

  // Beat fetch: from the AR channel when idle, from the burst address otherwise
  always_comb begin
    rf_addr  = (r_state == R_IDLE) ? axi.araddr  : r_addr;
    rf_size  = (r_state == R_IDLE) ? axi.arsize  : r_size;
    rf_burst = (r_state == R_IDLE) ? axi.arburst : r_burst;
    rf_idx   = word_idx(rf_addr);
    rf_bad   = bad_xfer(rf_size, rf_burst);
    rf_oob   = !in_range(rf_idx);
    rf_data  = '0;
    rf_resp  = 2'b00;
    if (rf_bad)      rf_resp = 2'b10;
    else if (rf_oob) rf_resp = 2'b11;
    else             rf_data = mem[rf_idx[IDX_W-1:0]];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= R_IDLE;
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_size    <= '0;
      r_burst   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
      rid_q     <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (axi.arvalid && arready_q) begin
            r_addr    <= next_addr(axi.araddr, axi.arsize, axi.arburst);
            r_len     <= axi.arlen;
            r_size    <= axi.arsize;
            r_burst   <= axi.arburst;
            r_cnt     <= '0;
            rid_q     <= axi.arid;
            rdata_q   <= rf_data;
            rresp_q   <= rf_resp;
            rlast_q   <= (axi.arlen == 8'd0);
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            r_state   <= R_DATA;
          end
        end
        R_DATA: begin
          if (rvalid_q && axi.rready) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              rdata_q   <= '0;
              rresp_q   <= 2'b00;
              arready_q <= 1'b1;
              r_state   <= R_IDLE;
            end else begin
              r_cnt   <= r_cnt + 8'd1;
              r_addr  <= next_addr(r_addr, r_size, r_burst);
              rdata_q <= rf_data;
              rresp_q <= rf_resp;
              rlast_q <= ((r_cnt + 8'd1) == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign axi.awready = awready_q;
  assign axi.wready  = wready_q;
  assign axi.bvalid  = bvalid_q;
  assign axi.bresp   = bresp_q;
  assign axi.bid     = bid_q;
  assign axi.arready = arready_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rlast   = rlast_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;
  assign axi.rid     = rid_q;
endmodule

// File: tb/tb_axi_slave_mem_responder.sv
// Bench for axi_slave_mem_responder: directed scenarios plus random bursts
// checked against a word-array memory model.
module tb_axi_slave_mem_responder;
  localparam int ID_W = 4, ADDR_W = 32, DATA_W = 64, MEM_DEPTH = 1024;

  logic aclk = 1'b0;
  logic aresetn = 1'b1;
  always #5 aclk = ~aclk;

  axi_slave_mem_responder_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  axi_slave_mem_responder #(
    .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH), .BASE_ADDR('0)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .axi(bus)
  );

  int errs = 0;
  int checks = 0;

  logic [63:0] mdl [int];
  logic [63:0] wd [256];
  logic [7:0]  ws [256];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [2:0] size,
                                            input logic [1:0] burst, input int i);
    return (burst == 2'b00) ? a : a + 32'(i) * (32'd1 << size);
  endfunction

  function automatic void exp_beat(input logic [31:0] a, input logic [2:0] size,
                                   input logic [1:0] burst, input int i,
                                   output logic [63:0] d, output logic [1:0] r);
    int unsigned ix;
    ix = beat_addr(a, size, burst, i) >> 3;
    d = '0;
    if (burst >= 2'd2 || size > 3'd3) r = 2'b10;
    else if (ix >= MEM_DEPTH)         r = 2'b11;
    else begin
      r = 2'b00;
      d = mdl.exists(int'(ix)) ? mdl[int'(ix)] : 64'h0;
    end
  endfunction

  // wlast_at: beat carrying wlast (negative or beyond len means never)
  task automatic do_write(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input int wlast_at, input int bstall);
    int nb, t;
    int unsigned ix;
    logic sl, dc;
    logic [1:0] er;
    nb = (wlast_at >= 0 && wlast_at <= int'(len)) ? wlast_at + 1 : int'(len) + 1;
    sl = (wlast_at != int'(len)) || burst >= 2'd2 || size > 3'd3;
    dc = 1'b0;
    if (burst < 2'd2 && size <= 3'd3) begin
      for (int i = 0; i < nb; i++) begin
        ix = beat_addr(a, size, burst, i) >> 3;
        if (ix >= MEM_DEPTH) dc = 1'b1;
        else begin
          if (!mdl.exists(int'(ix))) mdl[int'(ix)] = 64'h0;
          for (int b = 0; b < 8; b++)
            if (ws[i][b]) mdl[int'(ix)][b*8 +: 8] = wd[i][b*8 +: 8];
        end
      end
    end
    er = dc ? 2'b11 : (sl ? 2'b10 : 2'b00);

    @(posedge aclk); #1;
    bus.awid = id; bus.awaddr = a; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
    bus.awvalid = 1'b1;
    t = 0;
    @(negedge aclk);
    while (!bus.awready && t < 50) begin @(negedge aclk); t++; end
    chk("aw_accept", bus.awready, 1);
    @(posedge aclk); #1;
    bus.awvalid = 1'b0;
    for (int i = 0; i < nb; i++) begin
      bus.wdata = wd[i]; bus.wstrb = ws[i]; bus.wlast = (i == wlast_at); bus.wvalid = 1'b1;
      t = 0;
      @(negedge aclk);
      while (!bus.wready && t < 50) begin @(negedge aclk); t++; end
      chk("w_accept", bus.wready, 1);
      @(posedge aclk); #1;
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    @(negedge aclk);
    chk("b_latency", bus.bvalid, 1);
    chk("w_closed", bus.wready, 0);
    for (int s = 0; s < bstall; s++) begin
      chk("b_hold", bus.bvalid, 1);
      chk("b_hold_resp", bus.bresp, er);
      chk("aw_blocked", bus.awready, 0);
      @(negedge aclk);
    end
    bus.bready = 1'b1;
    chk("bvalid", bus.bvalid, 1);
    chk("bid", bus.bid, id);
    chk("bresp", bus.bresp, er);
    @(posedge aclk); #1;
    bus.bready = 1'b0;
    @(negedge aclk);
    chk("b_done", bus.bvalid, 0);
    chk("aw_rearm", bus.awready, 1);
  endtask

  // rpat bit c is rready in cycle c (1 afterwards); rnd overrides with random rready
  task automatic do_read(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input logic [15:0] rpat, input bit rnd);
    int t, k, c;
    logic rr, stalled;
    logic [63:0] ed, pd;
    logic [1:0] er, pr;
    logic pl;
    @(posedge aclk); #1;
    bus.arid = id; bus.araddr = a; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
    bus.arvalid = 1'b1; bus.rready = 1'b0;
    t = 0;
    @(negedge aclk);
    while (!bus.arready && t < 50) begin @(negedge aclk); t++; end
    chk("ar_accept", bus.arready, 1);
    @(posedge aclk); #1;
    bus.arvalid = 1'b0;
    @(negedge aclk);
    chk("r_latency", bus.rvalid, 1);
    k = 0; c = 0; stalled = 1'b0; pd = '0; pr = '0; pl = 1'b0;
    while (k <= int'(len) && c < 300) begin
      rr = rnd ? 1'($urandom_range(0, 1)) : ((c < 16) ? rpat[c] : 1'b1);
      bus.rready = rr;
      chk("r_valid_hold", bus.rvalid, 1);
      if (stalled) begin
        chk("r_stable_data", bus.rdata, pd);
        chk("r_stable_resp", bus.rresp, pr);
        chk("r_stable_last", bus.rlast, pl);
        chk("r_stable_id", bus.rid, id);
      end
      if (rr) begin
        exp_beat(a, size, burst, k, ed, er);
        chk("rdata", bus.rdata, ed);
        chk("rresp", bus.rresp, er);
        chk("rlast", bus.rlast, (k == int'(len)));
        chk("rid", bus.rid, id);
        k++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        pd = bus.rdata; pr = bus.rresp; pl = bus.rlast;
      end
      @(posedge aclk);
      c++;
      @(negedge aclk);
    end
    bus.rready = 1'b0;
    chk("r_beats", k, int'(len) + 1);
    chk("r_done_valid", bus.rvalid, 0);
    chk("r_done_last", bus.rlast, 0);
    chk("ar_rearm", bus.arready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached with %0d errors of %0d checks", errs, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] len;
    logic [2:0] sz;
    logic [1:0] bu;
    int ix, wl;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0;
    bus.arburst = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

    // reset and release
    #2 aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    chk("rst_ctrl", {bus.awready, bus.wready, bus.bvalid, bus.bresp, bus.bid, bus.arready,
                     bus.rvalid, bus.rlast, bus.rresp, bus.rid}, 0);
    chk("rst_rdata", bus.rdata, 0);
    aresetn = 1'b1;
    #1;
    chk("rel_awready_pre", bus.awready, 0);
    @(negedge aclk);
    chk("rel_awready", bus.awready, 1);
    chk("rel_arready", bus.arready, 1);

    // INCR write then read back
    for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
    do_write(4'd5, 32'h100, 8'd3, 3'd3, 2'b01, 3, 0);
    do_read(4'd9, 32'h100, 8'd3, 3'd3, 2'b01, 16'hFFFF, 1'b0);

    // byte strobes and FIXED burst
    wd[0] = 64'h1122334455667788; ws[0] = 8'hFF;
    do_write(4'd1, 32'h200, 8'd0, 3'd3, 2'b01, 0, 0);
    wd[0] = 64'hAAAAAAAABBBBBBBB; ws[0] = 8'h0F;
    do_write(4'd2, 32'h200, 8'd0, 3'd3, 2'b01, 0, 0);
    do_read(4'd3, 32'h200, 8'd0, 3'd3, 2'b01, 16'hFFFF, 1'b0);
    wd[0] = {$urandom, $urandom}; wd[1] = {$urandom, $urandom}; ws[0] = 8'hFF; ws[1] = 8'hFF;
    do_write(4'd4, 32'h208, 8'd1, 3'd3, 2'b00, 1, 0);
    do_read(4'd4, 32'h208, 8'd0, 3'd3, 2'b01, 16'hFFFF, 1'b0);

    // decode errors, WRAP, early wlast
    do_read(4'd6, 32'h2000, 8'd1, 3'd3, 2'b01, 16'hFFFF, 1'b0);
    do_write(4'd7, 32'h2000, 8'd0, 3'd3, 2'b01, 0, 0);
    do_read(4'd6, 32'h2000, 8'd0, 3'd3, 2'b01, 16'hFFFF, 1'b0);
    do_write(4'd8, 32'h100, 8'd0, 3'd3, 2'b10, 0, 0);
    do_read(4'd8, 32'h100, 8'd0, 3'd3, 2'b01, 16'hFFFF, 1'b0);
    for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
    do_write(4'd10, 32'h300, 8'd3, 3'd3, 2'b01, 1, 0);
    do_read(4'd10, 32'h300, 8'd1, 3'd3, 2'b01, 16'hFFFF, 1'b0);

    // backpressure on R, then stalled B with a concurrent read
    do_read(4'd11, 32'h100, 8'd2, 3'd3, 2'b01, 16'hFFF9, 1'b0);
    wd[0] = {$urandom, $urandom}; ws[0] = 8'hFF;
    fork
      do_write(4'd12, 32'h318, 8'd0, 3'd3, 2'b01, 0, 5);
      do_read(4'd13, 32'h100, 8'd3, 3'd3, 2'b01, 16'hFFFF, 1'b0);
    join

    // reset during beat 1 of a 4-beat read
    @(posedge aclk); #1;
    bus.arid = 4'd14; bus.araddr = 32'h100; bus.arlen = 8'd3; bus.arsize = 3'd3;
    bus.arburst = 2'b01; bus.arvalid = 1'b1; bus.rready = 1'b1;
    @(negedge aclk);
    chk("mid_ar_ready", bus.arready, 1);
    @(posedge aclk); #1;
    bus.arvalid = 1'b0;
    @(posedge aclk); #2;
    aresetn = 1'b0;
    #1;
    chk("mid_rst_rvalid", bus.rvalid, 0);
    chk("mid_rst_ctrl", {bus.awready, bus.arready, bus.rlast, bus.bvalid}, 0);
    bus.rready = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("mid_rel_arready", bus.arready, 1);
    chk("mid_rel_rvalid", bus.rvalid, 0);
    do_read(4'd15, 32'h100, 8'd3, 3'd3, 2'b01, 16'hFFFF, 1'b0);

    // preload random regions, then random write/read pairs
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 16; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
      do_write(4'(blk), 32'(blk * 128), 8'd15, 3'd3, 2'b01, 15, 0);
    end
    for (int i = 0; i < 8; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
    do_write(4'd0, 32'h1FC0, 8'd7, 3'd3, 2'b01, 7, 0);

    for (int it = 0; it < 30; it++) begin
      len = 8'($urandom_range(0, 7));
      sz  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd3;
      case ($urandom_range(0, 9))
        0:       bu = 2'($urandom_range(2, 3));
        1, 2:    bu = 2'b00;
        default: bu = 2'b01;
      endcase
      ix = ($urandom_range(0, 3) == 0) ? 1016 + int'($urandom_range(0, 15))
                                       : int'($urandom_range(0, 63 - int'(len)));
      for (int i = 0; i <= int'(len); i++) begin
        wd[i] = {$urandom, $urandom};
        ws[i] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
      end
      wl = ($urandom_range(0, 6) == 0) ? int'($urandom_range(0, 9)) : int'(len);
      do_write(4'($urandom), 32'(ix * 8), len, sz, bu, wl, int'($urandom_range(0, 3)));
      do_read(4'($urandom), 32'(ix * 8), len, sz, bu, 16'hFFFF, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
